// File: rtl/common_pkg.sv
// Shared constants and channel-state type for the multi-channel tick generator.
package common_pkg;

  localparam int TICK_GEN_NUM_OF_CH              = 4;
  localparam int TICK_GEN_PERIOD_WIDTH           = 24;
  localparam int TIMER_UNIT_CLASSIC_PULSE_PERIOD = 96;
  localparam int MAX_UART_BAID_PERIOD            = 16_777_215;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/tick_gen_channel.sv
// One tick channel: period register, down-counter and IDLE/RUN/DONE control.
// First tick appears P cycles after enable is sampled; tick and busy are registered.
module tick_gen_channel
  import common_pkg::*;
#(
  parameter int PERIOD_WIDTH   = TICK_GEN_PERIOD_WIDTH,
  parameter int DEFAULT_PERIOD = TIMER_UNIT_CLASSIC_PULSE_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en_i,
  input  logic [PERIOD_WIDTH-1:0] wr_period_i,
  input  logic                    enable_i,
  input  logic                    oneshot_i,
  input  logic                    restart_i,
  output logic                    tick_o,
  output logic                    busy_o
);

  localparam logic [PERIOD_WIDTH-1:0] RST_PERIOD = PERIOD_WIDTH'(DEFAULT_PERIOD);

  ch_state_e                 state_q;
  logic [PERIOD_WIDTH-1:0]   cnt_q;
  logic [PERIOD_WIDTH-1:0]   pr_q;
  logic [PERIOD_WIDTH-1:0]   pr_d;
  logic                      tick_q;
  logic                      busy_q;
  logic [PERIOD_WIDTH-1:0]   reload_cur;
  logic [PERIOD_WIDTH-1:0]   reload_restart;

  // A zero period behaves as a period of one, so the reload value is P-1.
  function automatic logic [PERIOD_WIDTH-1:0] reload_of(input logic [PERIOD_WIDTH-1:0] p);
    return (p == '0) ? '0 : p - PERIOD_WIDTH'(1);
  endfunction

  assign pr_d           = wr_en_i ? wr_period_i : pr_q;
  assign reload_cur     = reload_of(pr_q);
  assign reload_restart = reload_of(pr_d);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      pr_q    <= RST_PERIOD;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pr_q   <= pr_d;
      tick_q <= 1'b0;
      if (!enable_i) begin
        state_q <= CH_IDLE;
        busy_q  <= 1'b0;
      end else if (restart_i && (state_q != CH_IDLE)) begin
        // Restart wins over a pending expiry and sees a same-cycle period write.
        state_q <= CH_RUN;
        cnt_q   <= reload_restart;
        busy_q  <= 1'b1;
      end else begin
        unique case (state_q)
          CH_IDLE: begin
            state_q <= CH_RUN;
            cnt_q   <= reload_cur;
            busy_q  <= 1'b1;
          end
          CH_RUN: begin
            if (cnt_q == '0) begin
              tick_q <= 1'b1;
              if (oneshot_i) begin
                state_q <= CH_DONE;
                busy_q  <= 1'b0;
              end else begin
                cnt_q <= reload_cur;
              end
            end else begin
              cnt_q <= cnt_q - PERIOD_WIDTH'(1);
            end
          end
          CH_DONE: begin
            busy_q <= 1'b0;
          end
          default: begin
            state_q <= CH_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tick_o = tick_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Array of independent programmable tick channels sharing one period-write port.
// Writes to a channel index outside the array are dropped.
module tick_gen_multi
  import common_pkg::*;
#(
  parameter int NUM_OF_CH      = TICK_GEN_NUM_OF_CH,
  parameter int PERIOD_WIDTH   = TICK_GEN_PERIOD_WIDTH,
  parameter int DEFAULT_PERIOD = TIMER_UNIT_CLASSIC_PULSE_PERIOD,
  localparam int CH_W          = (NUM_OF_CH > 1) ? $clog2(NUM_OF_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [PERIOD_WIDTH-1:0] wr_period,
  input  logic [NUM_OF_CH-1:0]    ch_enable,
  input  logic [NUM_OF_CH-1:0]    ch_oneshot,
  input  logic [NUM_OF_CH-1:0]    ch_restart,
  output logic [NUM_OF_CH-1:0]    tick,
  output logic [NUM_OF_CH-1:0]    ch_busy
);

  logic [NUM_OF_CH-1:0] wr_sel;
  logic                 wr_ch_ok;

  assign wr_ch_ok = (32'(wr_ch) < 32'(NUM_OF_CH));

  for (genvar g = 0; g < NUM_OF_CH; g++) begin : g_ch
    assign wr_sel[g] = wr_en && wr_ch_ok && (32'(wr_ch) == 32'(g));

    tick_gen_channel #(
      .PERIOD_WIDTH   (PERIOD_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .wr_en_i     (wr_sel[g]),
      .wr_period_i (wr_period),
      .enable_i    (ch_enable[g]),
      .oneshot_i   (ch_oneshot[g]),
      .restart_i   (ch_restart[g]),
      .tick_o      (tick[g]),
      .busy_o      (ch_busy[g])
    );
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: directed scenarios plus random traffic against a deadline-based model.
module tb_tick_gen_multi;

  localparam int N  = 4;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [PW-1:0] wr_period;
  logic [N-1:0]  ch_enable, ch_oneshot, ch_restart;
  logic [N-1:0]  tick, ch_busy;

  // Three-channel instance where index 3 is representable but out of range.
  logic          o_wr_en;
  logic [1:0]    o_wr_ch;
  logic [PW-1:0] o_wr_period;
  logic [2:0]    o_en, o_zero;
  logic [2:0]    tick_odd, busy_odd;

  always #5 clk = ~clk;

  tick_gen_multi #(.NUM_OF_CH(N), .PERIOD_WIDTH(PW), .DEFAULT_PERIOD(96)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_period(wr_period),
    .ch_enable(ch_enable), .ch_oneshot(ch_oneshot), .ch_restart(ch_restart),
    .tick(tick), .ch_busy(ch_busy)
  );

  tick_gen_multi #(.NUM_OF_CH(3), .PERIOD_WIDTH(PW), .DEFAULT_PERIOD(96)) dut_odd (
    .clk(clk), .reset_n(reset_n), .wr_en(o_wr_en), .wr_ch(o_wr_ch), .wr_period(o_wr_period),
    .ch_enable(o_en), .ch_oneshot(o_zero), .ch_restart(o_zero),
    .tick(tick_odd), .ch_busy(busy_odd)
  );

  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;

  // Model: per channel a mode (0 idle, 1 running, 2 finished) and the absolute
  // edge number at which the next expiry is due.
  int           m_mode [N];
  longint       m_due  [N];
  int           m_pr   [N];
  logic [N-1:0] m_tick, m_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      m_tick[c] = 1'b0;
      if (!reset_n) begin
        m_mode[c] = 0;
        m_pr[c]   = 96;
      end else if (!ch_enable[c]) begin
        m_mode[c] = 0;
      end else if (ch_restart[c] && m_mode[c] != 0) begin
        m_mode[c] = 1;
        m_due[c]  = cyc + ((wr_en && int'(wr_ch) == c) ? eff(int'(wr_period)) : eff(m_pr[c]));
      end else if (m_mode[c] == 0) begin
        m_mode[c] = 1;
        m_due[c]  = cyc + eff(m_pr[c]);
      end else if (m_mode[c] == 1 && cyc == m_due[c]) begin
        m_tick[c] = 1'b1;
        if (ch_oneshot[c]) m_mode[c] = 2;
        else               m_due[c]  = cyc + eff(m_pr[c]);
      end
    end
    if (reset_n && wr_en) m_pr[int'(wr_ch)] = int'(wr_period);
    for (int c = 0; c < N; c++) m_busy[c] = (m_mode[c] == 1);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("tick", {60'd0, tick}, {60'd0, m_tick});
    chk("busy", {60'd0, ch_busy}, {60'd0, m_busy});
  endtask

  task automatic write_pr(input int ch, input int p);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_period = PW'(p);
    step();
    wr_en = 1'b0;
  endtask

  // Steps until the channel ticks or the budget runs out; k is the step count.
  task automatic wait_tick(input int ch, input int budget, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!tick[ch] && k < budget);
  endtask

  initial begin
    int cnt, cnt2, odd_cnt, odd_early, k;
    reset_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_period = '0;
    ch_enable = '0; ch_oneshot = '0; ch_restart = '0;
    o_wr_en = 1'b0; o_wr_ch = '0; o_wr_period = '0; o_en = '0; o_zero = '0;
    for (int c = 0; c < N; c++) begin m_mode[c] = 0; m_due[c] = 0; m_pr[c] = 96; end

    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Default period on ch0; odd instance gets a write to index 3 that must be dropped.
    ch_enable[0] = 1'b1;
    o_wr_en = 1'b1; o_wr_ch = 2'd3; o_wr_period = PW'(2);
    cnt = 0; odd_cnt = 0; odd_early = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (i == 0) begin o_wr_en = 1'b0; o_en = 3'b111; end
      cnt += int'(tick[0]);
      odd_cnt += $countones(tick_odd);
      if (i < 97 && tick_odd != 0) odd_early++;
    end
    chk("ch0_tick_count", cnt, 2);
    chk("odd_tick_count", odd_cnt, 6);
    chk("odd_early_ticks", odd_early, 0);
    chk("odd_busy", {61'd0, busy_odd}, 64'd7);
    ch_enable[0] = 1'b0; o_en = '0;
    step();

    // One-shot with P=5, then re-arm by toggling enable.
    write_pr(1, 5);
    ch_oneshot[1] = 1'b1; ch_enable[1] = 1'b1;
    cnt = 0;
    repeat (20) begin step(); cnt += int'(tick[1]); end
    chk("ch1_oneshot_ticks", cnt, 1);
    chk("ch1_busy_after", {63'd0, ch_busy[1]}, 64'd0);
    ch_enable[1] = 1'b0; step(); ch_enable[1] = 1'b1;
    cnt = 0;
    repeat (10) begin step(); cnt += int'(tick[1]); end
    chk("ch1_rearm_ticks", cnt, 1);
    ch_enable[1] = 1'b0; ch_oneshot[1] = 1'b0;

    // Periods 0 and 1 both tick every cycle.
    write_pr(2, 0);
    ch_enable[2] = 1'b1;
    cnt = 0;
    repeat (10) begin step(); cnt += int'(tick[2]); end
    chk("ch2_p0_ticks", cnt, 9);
    write_pr(2, 1);
    cnt = 0;
    repeat (10) begin step(); cnt += int'(tick[2]); end
    chk("ch2_p1_ticks", cnt, 10);
    ch_enable[2] = 1'b0;

    // P=10, shorten to 3 mid-count, then restart on the expiry cycle.
    write_pr(3, 10);
    ch_enable[3] = 1'b1;
    repeat (6) step();
    write_pr(3, 3);
    wait_tick(3, 30, k);
    chk("ch3_tick_on_schedule", k, 4);
    wait_tick(3, 30, k);
    chk("ch3_new_period", k, 3);
    repeat (2) step();
    ch_restart[3] = 1'b1;
    step();
    ch_restart[3] = 1'b0;
    chk("ch3_restart_suppress", {63'd0, tick[3]}, 64'd0);
    wait_tick(3, 30, k);
    chk("ch3_after_restart", k, 3);
    ch_enable = '0;
    step();

    // All channels at P=4 tick together.
    for (int c = 0; c < N; c++) write_pr(c, 4);
    ch_enable = '1;
    cnt = 0; cnt2 = 0;
    repeat (12) begin
      step();
      if (tick == '1) cnt++;
      else if (tick != '0) cnt2++;
    end
    chk("all_ch_ticks", cnt, 2);
    chk("partial_ticks", cnt2, 0);
    ch_enable = '0;
    step();

    // Reset with CNT=2 aborts silently and restores the default period.
    write_pr(0, 6);
    ch_enable[0] = 1'b1;
    repeat (4) step();
    reset_n = 1'b0;
    step();
    chk("rst_tick", {60'd0, tick}, 64'd0);
    chk("rst_busy", {60'd0, ch_busy}, 64'd0);
    reset_n = 1'b1;
    wait_tick(0, 200, k);
    chk("post_rst_latency", k, 97);
    ch_enable = '0;
    step();

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom % 400) != 0;
      for (int c = 0; c < N; c++) begin
        if ($urandom % 12 == 0) ch_enable[c]  = ~ch_enable[c];
        if ($urandom % 10 == 0) ch_oneshot[c] = ~ch_oneshot[c];
        ch_restart[c] = ($urandom % 15) == 0;
      end
      wr_en     = ($urandom % 6) == 0;
      wr_ch     = 2'($urandom_range(0, 3));
      wr_period = PW'($urandom_range(0, 9));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
